// File: rtl/mul_seq_unit.sv
// mul_seq_unit -- sequential shift-and-add 32x32 multiplier (low 32 bits).
//
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous active-high reset
//   start       in   1   begin an operation (only with ALUControl = VMUL)
//   ALUControl  in   3   operation code, 3'b110 = VMUL
//   SrcA        in  32   multiplicand, sampled at accept
//   SrcB        in  32   multiplier, sampled at accept
//   kill        in   1   abort, returns to IDLE on the next edge
//   Result      out 32   registered product (low 32 bits)
//   ALUFlags    out  4   registered {N,Z,C,V}
//   busy        out  1   registered, high while in BUSY
//   done        out  1   registered, high while in DONE
//   stall       out  1   combinational hold request to the issuing stage
//
// Optional macro MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always running 32 cycles.
module mul_seq_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        kill,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [2:0] OP_VMUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  count;
  logic [31:0] acc_sum;
  logic        accept;
  logic        last;

  assign accept = start && (ALUControl == OP_VMUL) && !kill &&
                  ((state == IDLE) || (state == DONE));

  // kill drops the hold immediately so the pipeline can flush this cycle.
  assign stall = !kill && ((state == BUSY) || accept);

  assign acc_sum = acc + (mplier[0] ? mcand : 32'd0);

`ifdef MUL_EARLY_TERM_EN
  // Post-shift multiplier is mplier >> 1; once that is zero no further
  // partial products can contribute.
  assign last = (count == 5'd31) || (mplier[31:1] == 31'd0);
`else
  assign last = (count == 5'd31);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == BUSY);
      done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = BUSY;
        BUSY:    if (last) state_next = DONE;
        DONE:    state_next = accept ? BUSY : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand    <= 32'd0;
      mplier   <= 32'd0;
      acc      <= 32'd0;
      count    <= 5'd0;
      Result   <= 32'd0;
      ALUFlags <= 4'b0000;
    end else if (accept) begin
      mcand  <= SrcA;
      mplier <= SrcB;
      acc    <= 32'd0;
      count  <= 5'd0;
    end else if ((state == BUSY) && !kill) begin
      mcand  <= {mcand[30:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
      acc    <= acc_sum;
      count  <= count + 5'd1;
      if (last) begin
        Result   <= acc_sum;
        ALUFlags <= {acc_sum[31], (acc_sum == 32'd0), 1'b0, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_unit.sv
module tb_mul_seq_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        kill;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;
  logic        busy;
  logic        done;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .kill       (kill),
    .Result     (Result),
    .ALUFlags   (ALUFlags),
    .busy       (busy),
    .done       (done),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Counts negedges with busy high; bounded so a stuck DUT cannot hang the run.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags,
                        input int exp_len);
    int cycles;
    @(negedge clk);
    start = 1'b1; ALUControl = 3'b110; SrcA = a; SrcB = b;
    #1;
    check({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_busy(cycles);
    check({tag, "_busy_len"}, cycles, exp_len);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, Result, exp_res);
    check({tag, "_flags"}, {28'd0, ALUFlags}, {28'd0, exp_flags});
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    $display("op %s: %0h * %0h -> %0h flags %b busy %0d cycles", tag, a, b, Result, ALUFlags, cycles);
  endtask

  initial begin
    int cycles;
    int kill_cycle;
    int saw_done;
    reset = 1'b1; start = 1'b0; ALUControl = 3'b000; SrcA = 32'd0; SrcB = 32'd0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", Result, 32'd0);
    check("reset_flags", {28'd0, ALUFlags}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // First accept directly after reset release.
`ifdef MUL_EARLY_TERM_EN
    run_op("7x6", 32'd7, 32'd6, 32'h2A, 4'b0000, 3);
    run_op("ffx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'b1000, 2);
    run_op("x0", 32'h12345678, 32'd0, 32'd0, 4'b0100, 1);
    run_op("7x6b", 32'd7, 32'd6, 32'h2A, 4'b0000, 3);
    kill_cycle = 2;
`else
    run_op("7x6", 32'd7, 32'd6, 32'h2A, 4'b0000, 32);
    run_op("ffx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'b1000, 32);
    run_op("x0", 32'h12345678, 32'd0, 32'd0, 4'b0100, 32);
    run_op("7x6b", 32'd7, 32'd6, 32'h2A, 4'b0000, 32);
    kill_cycle = 10;
`endif

    // Kill mid-operation.
    start = 1'b1; ALUControl = 3'b110; SrcA = 32'd5; SrcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (kill_cycle - 1) @(negedge clk);
    check("kill_busy_before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    start = 1'b1;
    #1;
    check("kill_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_result", Result, 32'h2A);
    check("kill_flags", {28'd0, ALUFlags}, 32'd0);
    saw_done = 0;
    repeat (4) begin
      if (done) saw_done = 1;
      if (busy) saw_done = 1;
      @(negedge clk);
    end
    check("kill_no_done", saw_done, 0);
    $display("op kill: aborted in busy cycle %0d, Result %0h", kill_cycle, Result);

    // Non-multiply opcode is ignored.
    start = 1'b1; ALUControl = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    #1;
    check("nonmul_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("nonmul_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    $display("op nonmul: start with ALUControl=000 ignored");

    // Back-to-back: accept again in the DONE cycle.
    @(negedge clk);
    start = 1'b1; ALUControl = 3'b110; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cycles);
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_res1", Result, 32'd12);
    start = 1'b1; SrcA = 32'd9; SrcB = 32'd3;
    #1;
    check("b2b_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_busy(cycles);
`ifdef MUL_EARLY_TERM_EN
    check("b2b_len", cycles, 2);
`else
    check("b2b_len", cycles, 32);
`endif
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_res2", Result, 32'h1B);
    check("b2b_flags2", {28'd0, ALUFlags}, 32'd0);
    $display("op b2b: 3*4 then 9*3 -> %0h", Result);
    @(negedge clk);

    // Reset in BUSY cycle 5.
    start = 1'b1; ALUControl = 3'b110; SrcA = 32'd7; SrcB = 32'h100;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_flags", {28'd0, ALUFlags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (3) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    check("rst_no_done", saw_done, 0);
    $display("op reset: abandoned in busy cycle 5");

`ifdef MUL_EARLY_TERM_EN
    run_op("after_rst", 32'd7, 32'h100, 32'h700, 4'b0000, 9);
`else
    run_op("after_rst", 32'd7, 32'h100, 32'h700, 4'b0000, 32);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
